// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: RAM command opcodes and arbiter FSM state encoding
package ram_ctrl_pkg;
  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;
  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_CMD, RD_WAIT, RESP} state_t;
endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: two-way round-robin grant; pointer holds the last granted requester
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);
  logic last;
  always_comb grant = (&req) ? (last ? 2'b01 : 2'b10) : req;
  // reset to "last = 1" so requester 0 wins the first contention
  always_ff @(posedge clk)
    if (!rst_n) last <= 1'b1;
    else if (advance && |grant) last <= grant[1];
endmodule

// File: rtl/ram_cmd_arbiter.sv
// ram_cmd_arbiter: shares a single-port command RAM between two requesters.
// ADDR_CACHE_EN skips the address command when it repeats the last one issued.
module ram_cmd_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_SIZE  = 8,
  parameter int WORD_SIZE  = 8,
  parameter int INPUT_SIZE = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             req_valid,
  input  logic [1:0]             req_we,
  input  logic [2*ADDR_SIZE-1:0] req_addr,
  input  logic [2*WORD_SIZE-1:0] req_wdata,
  output logic [1:0]             req_ready,
  output logic [1:0]             rsp_valid,
  output logic [WORD_SIZE-1:0]   rsp_rdata,
  output logic                   rsp_err,
  output logic [INPUT_SIZE-1:0]  ram_din,
  output logic                   ram_rx_valid,
  input  logic [WORD_SIZE-1:0]   ram_dout,
  input  logic                   ram_tx_valid
);
  state_t state;
  logic owner, g, g_we, accept, wr_hit, rd_hit;
  logic [1:0] grant;
  logic [ADDR_SIZE-1:0] g_addr;
  logic [WORD_SIZE-1:0] g_wdata, wdata;
  assign accept = state == IDLE && |req_valid;
  assign req_ready = state == IDLE ? grant : 2'b00;
  assign g = grant[1];
  assign g_we = req_we[g];
  assign g_addr = g ? req_addr[2*ADDR_SIZE-1:ADDR_SIZE] : req_addr[ADDR_SIZE-1:0];
  assign g_wdata = g ? req_wdata[2*WORD_SIZE-1:WORD_SIZE] : req_wdata[WORD_SIZE-1:0];
  rr_arbiter_2 u_rr (.clk(clk), .rst_n(rst_n), .req(req_valid), .advance(accept), .grant(grant));
`ifdef ADDR_CACHE_EN
  logic [ADDR_SIZE-1:0] last_wr_addr, last_rd_addr;
  logic last_wr_ok, last_rd_ok;
  assign wr_hit = last_wr_ok && last_wr_addr == g_addr;
  assign rd_hit = last_rd_ok && last_rd_addr == g_addr;
  // a miss always issues the address command, so the entry is refreshed at accept
  always_ff @(posedge clk)
    if (!rst_n) begin
      last_wr_addr <= '0;
      last_rd_addr <= '0;
      last_wr_ok <= 1'b0;
      last_rd_ok <= 1'b0;
    end else if (accept && g_we && !wr_hit) begin
      last_wr_addr <= g_addr;
      last_wr_ok <= 1'b1;
    end else if (accept && !g_we && !rd_hit) begin
      last_rd_addr <= g_addr;
      last_rd_ok <= 1'b1;
    end
`else
  assign wr_hit = 1'b0;
  assign rd_hit = 1'b0;
`endif
  // outputs are loaded on entry to each state so they reflect the state they are seen in
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= 1'b0;
      wdata <= '0;
      ram_din <= '0;
      ram_rx_valid <= 1'b0;
      rsp_valid <= 2'b00;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
    end else begin
      ram_rx_valid <= 1'b0;
      ram_din <= '0;
      rsp_valid <= 2'b00;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          owner <= g;
          wdata <= g_wdata;
          ram_rx_valid <= 1'b1;
          state <= g_we ? (wr_hit ? WR_DATA : WR_ADDR) : (rd_hit ? RD_CMD : RD_ADDR);
          ram_din <= g_we ? (wr_hit ? {OP_WR_DATA, g_wdata} : {OP_WR_ADDR, WORD_SIZE'(g_addr)})
                          : (rd_hit ? {OP_RD_DATA, {WORD_SIZE{1'b0}}} : {OP_RD_ADDR, WORD_SIZE'(g_addr)});
        end
        WR_ADDR: begin
          ram_rx_valid <= 1'b1;
          ram_din <= {OP_WR_DATA, wdata};
          state <= WR_DATA;
        end
        WR_DATA: begin
          rsp_valid <= owner ? 2'b10 : 2'b01;
          state <= RESP;
        end
        RD_ADDR: begin
          ram_rx_valid <= 1'b1;
          ram_din <= {OP_RD_DATA, {WORD_SIZE{1'b0}}};
          state <= RD_CMD;
        end
        RD_CMD: state <= RD_WAIT;
        RD_WAIT: begin
          rsp_valid <= owner ? 2'b10 : 2'b01;
          rsp_rdata <= ram_dout;
          rsp_err <= ~ram_tx_valid;
          state <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_cmd_arbiter.sv
// tb_ram_cmd_arbiter: directed vectors against the arbiter with a command RAM model behind it
module tb_ram_cmd_arbiter;
  logic clk = 1'b0, rst_n = 1'b0, mute = 1'b0;
  logic [1:0] req_valid = '0, req_we = '0, req_ready, rsp_valid;
  logic [15:0] req_addr = '0, req_wdata = '0;
  logic [7:0] rsp_rdata, ram_dout = '0, wa = '0, ra = '0;
  logic rsp_err, ram_rx_valid, ram_tx_valid = 1'b0;
  logic [9:0] ram_din;
  logic [7:0] mem [256];
  logic [9:0] cmds [$];
  int cyc = 0, vecs = 0, errs = 0;

  typedef struct {
    int id; bit we; logic [7:0] a, d; bit m;
    logic [7:0] er; bit ee; int lat, nc; logic [9:0] c0, c1; string nm;
  } vec_t;
  vec_t tbl [8];

  ram_cmd_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .ram_din(ram_din), .ram_rx_valid(ram_rx_valid), .ram_dout(ram_dout),
    .ram_tx_valid(ram_tx_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // command RAM: address commands latch, data/read commands act; read data one cycle later
  always @(posedge clk) begin
    ram_tx_valid <= 1'b0;
    if (ram_rx_valid) begin
      cmds.push_back(ram_din);
      case (ram_din[9:8])
        2'b00: wa <= ram_din[7:0];
        2'b01: mem[wa] <= ram_din[7:0];
        2'b10: ra <= ram_din[7:0];
        default: begin
          ram_dout <= mem[ra];
          ram_tx_valid <= !mute;
        end
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic txn(input vec_t v);
    int n0, lastc;
    bit got;
    @(negedge clk);
    mute = v.m;
    req_we[v.id] = v.we;
    req_addr[v.id*8 +: 8] = v.a;
    req_wdata[v.id*8 +: 8] = v.d;
    req_valid[v.id] = 1'b1;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      #1;
      if (req_ready[v.id]) got = 1;
      else @(negedge clk);
    end
    chk({v.nm, " accept"}, 32'(got), 1);
    n0 = cyc;
    @(negedge clk);
    req_valid[v.id] = 1'b0;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      if (rsp_valid != 2'b00) got = 1;
      else @(negedge clk);
    end
    chk({v.nm, " rsp seen"}, 32'(got), 1);
    chk({v.nm, " latency"}, 32'(cyc - n0), 32'(v.lat));
    chk({v.nm, " owner"}, 32'(rsp_valid), 32'(1 << v.id));
    chk({v.nm, " rdata"}, 32'(rsp_rdata), 32'(v.er));
    chk({v.nm, " err"}, 32'(rsp_err), 32'(v.ee));
    chk({v.nm, " ncmds"}, 32'(cmds.size()), 32'(v.nc));
    if (cmds.size() > 0) chk({v.nm, " cmd0"}, 32'(cmds[0]), 32'(v.c0));
    if (v.nc > 1 && cmds.size() > 1) chk({v.nm, " cmd1"}, 32'(cmds[1]), 32'(v.c1));
    @(negedge clk);
    chk({v.nm, " rsp one cycle"}, 32'(rsp_valid), 0);
    cmds.delete();
    mute = 1'b0;
    lastc = cyc;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cmds.delete();
  endtask

  initial begin
    int n, lastc;
    bit exp_owner;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    tbl[0] = '{0, 1, 8'h05, 8'hA5, 0, 8'h00, 0, 3, 2, 10'h005, 10'h1A5, "wr05 req0"};
    tbl[1] = '{1, 0, 8'h05, 8'h00, 0, 8'hA5, 0, 4, 2, 10'h205, 10'h300, "rd05 req1"};
    tbl[2] = '{0, 1, 8'h80, 8'h5A, 0, 8'h00, 0, 3, 2, 10'h080, 10'h15A, "wr80 req0"};
    tbl[3] = '{0, 0, 8'h80, 8'h00, 0, 8'h5A, 0, 4, 2, 10'h280, 10'h300, "rd80 req0"};
    tbl[4] = '{0, 1, 8'h00, 8'hC3, 0, 8'h00, 0, 3, 2, 10'h000, 10'h1C3, "wr00 req0"};
    tbl[5] = '{0, 0, 8'h00, 8'h00, 1, 8'hC3, 1, 4, 2, 10'h200, 10'h300, "rd00 no tx_valid"};
    tbl[6] = '{1, 1, 8'h01, 8'h11, 0, 8'h00, 0, 3, 2, 10'h001, 10'h111, "wr01 req1"};
    tbl[7] = '{1, 1, 8'h02, 8'h22, 0, 8'h00, 0, 3, 2, 10'h002, 10'h122, "wr02 req1"};
    repeat (3) @(negedge clk);
    chk("reset req_ready", 32'(req_ready), 0);
    chk("reset rsp_valid", 32'(rsp_valid), 0);
    chk("reset rsp_rdata", 32'(rsp_rdata), 0);
    chk("reset rsp_err", 32'(rsp_err), 0);
    chk("reset ram_din", 32'(ram_din), 0);
    chk("reset ram_rx_valid", 32'(ram_rx_valid), 0);
    rst_n = 1'b1;
    cmds.delete();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) txn(tbl[i]);

    // both requesters hold reads: grants alternate 0,1,0,1 at one per 5 cycles
    @(negedge clk);
    req_we = 2'b00;
    req_addr = {8'h02, 8'h01};
    req_valid = 2'b11;
    exp_owner = 1'b0;
    n = 0;
    lastc = 0;
    for (int k = 0; k < 60 && n < 4; k++) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) begin
        chk("rr owner", 32'(rsp_valid), exp_owner ? 32'd2 : 32'd1);
        chk("rr rdata", 32'(rsp_rdata), exp_owner ? 32'h22 : 32'h11);
        if (n > 0) chk("rr spacing", 32'(cyc - lastc), 5);
        lastc = cyc;
        exp_owner = !exp_owner;
        n++;
      end
    end
    req_valid = 2'b00;
    chk("rr count", 32'(n), 4);
    repeat (3) @(negedge clk);
    cmds.delete();

    // reset while the read command is on the bus drops the transaction
    @(negedge clk);
    req_we[0] = 1'b0;
    req_addr[7:0] = 8'h05;
    req_valid[0] = 1'b1;
    #1 chk("midrst accept", 32'(req_ready), 1);
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("midrst in RD_CMD", 32'({ram_rx_valid, ram_din}), 32'h700);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst rsp_valid", 32'(rsp_valid), 0);
    chk("midrst rx_valid", 32'(ram_rx_valid), 0);
    rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rsp_valid != 2'b00 || ram_rx_valid) n++;
    end
    chk("midrst quiet after", 32'(n), 0);
    cmds.delete();
    txn('{1, 1, 8'hFF, 8'h3C, 0, 8'h00, 0, 3, 2, 10'h0FF, 10'h13C, "post-rst wrFF"});
    txn('{0, 0, 8'hFF, 8'h00, 0, 8'h3C, 0, 4, 2, 10'h2FF, 10'h300, "post-rst rdFF"});

    // idle requester toggling: quiet bus between transactions is checked by ncmds
    repeat (4) @(negedge clk);
    txn('{0, 1, 8'h40, 8'h99, 0, 8'h00, 0, 3, 2, 10'h040, 10'h199, "toggle wr40"});
    repeat (2) @(negedge clk);
    txn('{0, 1, 8'h41, 8'h98, 0, 8'h00, 0, 3, 2, 10'h041, 10'h198, "toggle wr41"});

`ifdef ADDR_CACHE_EN
    pulse_reset();
    txn('{0, 1, 8'h10, 8'h77, 0, 8'h00, 0, 3, 2, 10'h010, 10'h177, "cache wr10 miss"});
    txn('{0, 1, 8'h10, 8'h88, 0, 8'h00, 0, 2, 1, 10'h188, 10'h000, "cache wr10 hit"});
    txn('{1, 0, 8'h10, 8'h00, 0, 8'h88, 0, 4, 2, 10'h210, 10'h300, "cache rd10 miss"});
    txn('{1, 0, 8'h10, 8'h00, 0, 8'h88, 0, 3, 1, 10'h300, 10'h000, "cache rd10 hit"});
    pulse_reset();
    txn('{0, 0, 8'h10, 8'h00, 0, 8'h88, 0, 4, 2, 10'h210, 10'h300, "cache rd10 after rst"});
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
